// File: rtl/fir_pkg.sv
// Shared definitions for the FIR streaming front end: default sizes, sample type and FSM states.
package fir_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int Q_FORMAT   = DATA_WIDTH / 2;
   localparam int NUM_REGS   = 8;

   typedef logic signed [DATA_WIDTH-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } fir_state_e;

   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_tap_stream_if.sv
// Bundle of the sample stream, coefficient write port, mac taps and result stream of fir_tap_stream.
interface fir_tap_stream_if #(
   parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = fir_pkg::NUM_REGS
);
   localparam int AW = fir_pkg::addr_width(NUM_REGS);

   logic [DATA_WIDTH-1:0]                sampleIn;
   logic                                 sampleValid;
   logic                                 sampleReady;
   logic                                 coefWrEn;
   logic [AW-1:0]                        coefAddr;
   logic [DATA_WIDTH-1:0]                coefData;
   logic                                 coefErr;
   logic                                 clearTaps;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  pDataOut;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  coefsOut;
   logic [DATA_WIDTH-1:0]                macResult;
   logic [DATA_WIDTH-1:0]                resultOut;
   logic                                 resultValid;
   logic                                 resultReady;
   logic                                 primed;

   modport slave (
      input  sampleIn, sampleValid, coefWrEn, coefAddr, coefData, clearTaps,
             macResult, resultReady,
      output sampleReady, coefErr, pDataOut, coefsOut, resultOut, resultValid, primed
   );

   modport master (
      output sampleIn, sampleValid, coefWrEn, coefAddr, coefData, clearTaps,
             macResult, resultReady,
      input  sampleReady, coefErr, pDataOut, coefsOut, resultOut, resultValid, primed
   );

endinterface

// File: rtl/fir_tap_line.sv
// Tap delay line: shifts a new sample into tap 0 on load, flushes to zero on clear.
module fir_tap_line #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rstN,
   input  logic                         load,
   input  logic                         clear,
   input  logic [WIDTH-1:0]             din,
   output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         taps <= '0;
      end else if (clear) begin
         taps <= '0;
      end else if (load) begin
         taps[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            taps[i] <= taps[i-1];
         end
      end
   end

endmodule

// File: rtl/fir_tap_stream.sv
// FIR front end: sample intake, coefficient bank, fill tracking and registered mac result stream.
//  state  | meaning
//  IDLE   | waiting for a sample; coefficient writes allowed
//  SETTLE | taps/coefs stable at the mac; capture macResult
//  HOLD   | result presented, held until the sink accepts
module fir_tap_stream
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = fir_pkg::NUM_REGS
) (
   input  logic             clk,
   input  logic             rstN,
   fir_tap_stream_if.slave  bus
);

   localparam int AW = addr_width(NUM_REGS);
   localparam int CW = $clog2(NUM_REGS + 1);

   fir_state_e                          state_q;
   fir_state_e                          state_d;
   logic                                accept;
   logic                                addr_ok;
   logic                                coef_ok;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] coef_q;
   logic [CW-1:0]                       fill_q;
   logic [DATA_WIDTH-1:0]               result_q;
   logic                                valid_q;
   logic                                err_q;

   // Ready follows resultReady combinationally so a held result can hand off back-to-back.
   assign bus.sampleReady = rstN & ~bus.clearTaps &
                            ((state_q == IDLE) | ((state_q == HOLD) & bus.resultReady));
   assign accept = bus.sampleValid & bus.sampleReady;

   if (NUM_REGS == (1 << AW)) begin : g_addr_pow2
      assign addr_ok = 1'b1;
   end else begin : g_addr_range
      assign addr_ok = (int'(bus.coefAddr) < NUM_REGS);
   end

   assign coef_ok = bus.coefWrEn & (state_q == IDLE) & ~bus.clearTaps & addr_ok;

   always_comb begin
      state_d = state_q;
      if (bus.clearTaps) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = SETTLE;
            SETTLE:  state_d = HOLD;
            HOLD:    if (bus.resultReady) state_d = accept ? SETTLE : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else if (bus.clearTaps) begin
         valid_q  <= 1'b0;
      end else if (state_q == SETTLE) begin
         result_q <= bus.macResult;
         valid_q  <= 1'b1;
      end else if ((state_q == HOLD) && bus.resultReady) begin
         valid_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         coef_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (coef_ok) coef_q[bus.coefAddr] <= bus.coefData;
         err_q <= bus.coefWrEn & ~coef_ok;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         fill_q <= '0;
      end else if (bus.clearTaps) begin
         fill_q <= '0;
      end else if (accept && (fill_q != CW'(NUM_REGS))) begin
         fill_q <= fill_q + 1'b1;
      end
   end

   fir_tap_line #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (NUM_REGS)
   ) u_tap_line (
      .clk   (clk),
      .rstN  (rstN),
      .load  (accept),
      .clear (bus.clearTaps),
      .din   (bus.sampleIn),
      .taps  (bus.pDataOut)
   );

   assign bus.coefsOut    = coef_q;
   assign bus.resultOut   = result_q;
   assign bus.resultValid = valid_q;
   assign bus.coefErr     = err_q;
   assign bus.primed      = (fill_q == CW'(NUM_REGS));

endmodule
